// File: rtl/cache_seq_pkg.sv
// Shared definitions for the cache access sequencer and the cache top level.
// Holds the sequencer state encoding and the default bus widths, so both
// sides of the cache interface agree on address, data and counter sizes.
package cache_seq_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cache_access_sequencer.sv
// cache_access_sequencer
// Walks a programmed range of word addresses into the direct-mapped cache,
// advancing on every completion beat. It sums the returned data and sorts
// each access into hit or miss by its latency in cycles.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a run (accepted in IDLE or DONE only)
//   baseAddr         first word address of the run
//   numAccesses      number of accesses; 0 finishes immediately
//   outData          read data from the cache, valid with outDataReady
//   outDataReady     completion beat
//   increment        controller advance strobe, cross-checked against the beat
//   address          address presented to the cache
//   busy / done      high in RUN / DONE
//   dataSum          wrapping sum of all beats of the run
//   hitCount         saturating count of accesses with latency <= HIT_MAX_CYC
//   missCount        saturating count of the remaining accesses
//   protocolErr      sticky flag: increment and outDataReady disagreed in RUN
module cache_access_sequencer #(
  parameter int ADDR_W      = cache_seq_pkg::ADDR_W,
  parameter int DATA_W      = cache_seq_pkg::DATA_W,
  parameter int CNT_W       = cache_seq_pkg::CNT_W,
  parameter int HIT_MAX_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [CNT_W-1:0]  numAccesses,
  input  logic [DATA_W-1:0] outData,
  input  logic              outDataReady,
  input  logic              increment,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dataSum,
  output logic [CNT_W-1:0]  hitCount,
  output logic [CNT_W-1:0]  missCount,
  output logic              protocolErr
);

  import cache_seq_pkg::*;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  // lat_q holds (latency - 1) of the access in flight, so "latency <= HIT_MAX_CYC"
  // becomes "lat_q < HIT_MAX_CYC" and cannot overflow at saturation.
  localparam logic [CNT_W-1:0]  HIT_LIM  = CNT_W'(HIT_MAX_CYC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic              perr_q, perr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    sum_d   = sum_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    perr_d  = perr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sum_d  = '0;
          hit_d  = '0;
          miss_d = '0;
          perr_d = 1'b0;
          lat_d  = '0;
          if (numAccesses != '0) begin
            addr_d  = baseAddr;
            rem_d   = numAccesses;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (increment ^ outDataReady) perr_d = 1'b1;
        if (outDataReady) begin
          sum_d = sum_q + outData;
          if (lat_q < HIT_LIM) hit_d  = sat_inc(hit_q);
          else                 miss_d = sat_inc(miss_q);
          lat_d = '0;
          rem_d = rem_q - CNT_ONE;
          // The final beat leaves the last issued address on the bus.
          if (rem_q == CNT_ONE) state_d = ST_DONE;
          else                  addr_d  = addr_q + ADDR_ONE;
        end else begin
          lat_d = sat_inc(lat_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      sum_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      sum_q   <= sum_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      perr_q  <= perr_d;
    end
  end

  assign address     = addr_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign dataSum     = sum_q;
  assign hitCount    = hit_q;
  assign missCount   = miss_q;
  assign protocolErr = perr_q;

endmodule

// File: tb/tb_cache_access_sequencer.sv
module tb_cache_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] baseAddr;
  logic [15:0] numAccesses;
  logic [31:0] outData;
  logic        outDataReady;
  logic        increment;
  logic [14:0] address;
  logic        busy;
  logic        done;
  logic [31:0] dataSum;
  logic [15:0] hitCount;
  logic [15:0] missCount;
  logic        protocolErr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_access_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr),
    .numAccesses(numAccesses), .outData(outData), .outDataReady(outDataReady),
    .increment(increment), .address(address), .busy(busy), .done(done),
    .dataSum(dataSum), .hitCount(hitCount), .missCount(missCount),
    .protocolErr(protocolErr)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; outDataReady = 1'b0; increment = 1'b0;
    outData = '0; baseAddr = '0; numAccesses = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run(input logic [14:0] base, input logic [15:0] n);
    start = 1'b1; baseAddr = base; numAccesses = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cache model: complete the access currently presented after 'lat' cycles
  // (lat=1 means the beat comes in the first cycle the address is shown).
  task automatic beat(input logic [31:0] data, input int lat, output logic [14:0] addr_seen);
    for (int i = 1; i < lat; i++) @(negedge clk);
    addr_seen = address;
    outData = data; outDataReady = 1'b1; increment = 1'b1;
    @(negedge clk);
    outData = '0; outDataReady = 1'b0; increment = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (address !== 15'h0) begin n_fail++; $display("FAIL reset_address: got %0h expected 0", address); end
    n_checks++; if ({busy, done, protocolErr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, protocolErr}); end
    n_checks++; if ({dataSum, hitCount, missCount} !== 64'h0) begin n_fail++; $display("FAIL reset_stats: got %0h expected 0", {dataSum, hitCount, missCount}); end
  endtask

  task automatic test_all_hit();
    logic [14:0] a [4];
    do_reset();
    start_run(15'h0010, 16'd4);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL allhit_busy_rise: got %b expected 1", busy); end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL allhit_early_done: got %b expected 0", done); end
      end
      beat(32'(i + 1), 1, a[i]);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (a[i] !== 15'(16 + i)) begin n_fail++; $display("FAIL allhit_addr%0d: got %0h expected %0h", i, a[i], 15'(16 + i)); end
    end
    n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL allhit_done: got %b expected 10", {done, busy}); end
    n_checks++; if (dataSum !== 32'd10) begin n_fail++; $display("FAIL allhit_sum: got %0d expected 10", dataSum); end
    n_checks++; if (hitCount !== 16'd4) begin n_fail++; $display("FAIL allhit_hits: got %0d expected 4", hitCount); end
    n_checks++; if (missCount !== 16'd0) begin n_fail++; $display("FAIL allhit_misses: got %0d expected 0", missCount); end
    n_checks++; if (address !== 15'h0013) begin n_fail++; $display("FAIL allhit_addr_hold: got %0h expected 13", address); end
    // A beat outside RUN must be ignored.
    outData = 32'd100; outDataReady = 1'b1; increment = 1'b1;
    @(negedge clk);
    outData = '0; outDataReady = 1'b0; increment = 1'b0;
    n_checks++; if ({dataSum, address} !== {32'd10, 15'h0013}) begin n_fail++; $display("FAIL done_beat_ignored: got %0h/%0h expected 10/13", dataSum, address); end
  endtask

  task automatic test_miss_latency();
    logic [14:0] a;
    do_reset();
    start_run(15'h0200, 16'd3);
    beat(32'd7, 5, a);
    beat(32'd8, 1, a);
    beat(32'd9, 1, a);
    n_checks++; if (hitCount !== 16'd2) begin n_fail++; $display("FAIL miss_hits: got %0d expected 2", hitCount); end
    n_checks++; if (missCount !== 16'd1) begin n_fail++; $display("FAIL miss_misses: got %0d expected 1", missCount); end
    n_checks++; if (dataSum !== 32'd24) begin n_fail++; $display("FAIL miss_sum: got %0d expected 24", dataSum); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL miss_done: got %b expected 1", done); end
  endtask

  task automatic test_wrap();
    logic [14:0] a0, a1, a2;
    do_reset();
    start_run(15'h7FFE, 16'd3);
    beat(32'hFFFF_FFFF, 1, a0);
    beat(32'd1, 1, a1);
    beat(32'd1, 1, a2);
    n_checks++; if ({a0, a1, a2} !== {15'h7FFE, 15'h7FFF, 15'h0000}) begin n_fail++; $display("FAIL wrap_addrs: got %0h %0h %0h expected 7ffe 7fff 0", a0, a1, a2); end
    n_checks++; if (dataSum !== 32'd1) begin n_fail++; $display("FAIL wrap_sum: got %0h expected 1", dataSum); end
    n_checks++; if (hitCount !== 16'd3) begin n_fail++; $display("FAIL wrap_hits: got %0d expected 3", hitCount); end
  endtask

  task automatic test_protocol_err();
    logic [14:0] a;
    do_reset();
    start_run(15'h0100, 16'd3);
    beat(32'd1, 1, a);
    n_checks++; if (protocolErr !== 1'b0) begin n_fail++; $display("FAIL perr_early: got %b expected 0", protocolErr); end
    increment = 1'b1;
    @(negedge clk);
    increment = 1'b0;
    n_checks++; if (protocolErr !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b expected 1", protocolErr); end
    n_checks++; if (address !== 15'h0101) begin n_fail++; $display("FAIL perr_addr: got %0h expected 101", address); end
    beat(32'd2, 1, a);   // latency 2 because of the stray increment cycle
    beat(32'd3, 1, a);
    n_checks++; if (protocolErr !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b expected 1", protocolErr); end
    n_checks++; if ({hitCount, missCount} !== {16'd2, 16'd1}) begin n_fail++; $display("FAIL perr_counts: got %0d/%0d expected 2/1", hitCount, missCount); end
    n_checks++; if ({dataSum, done} !== {32'd6, 1'b1}) begin n_fail++; $display("FAIL perr_final: got %0d/%b expected 6/1", dataSum, done); end
  endtask

  task automatic test_zero_and_restart();
    logic [14:0] a0, a1;
    do_reset();
    start_run(15'h0033, 16'd0);
    n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL zero_done: got %b expected 10", {done, busy}); end
    n_checks++; if ({dataSum, hitCount, missCount, address} !== 79'h0) begin n_fail++; $display("FAIL zero_stats: got %0h expected 0", {dataSum, hitCount, missCount, address}); end
    start_run(15'h0020, 16'd2);
    n_checks++; if ({busy, address} !== {1'b1, 15'h0020}) begin n_fail++; $display("FAIL restart_first: got %b/%0h expected 1/20", busy, address); end
    start_run(15'h0500, 16'd7);   // ignored while running
    n_checks++; if ({busy, address} !== {1'b1, 15'h0020}) begin n_fail++; $display("FAIL restart_ignore_start: got %b/%0h expected 1/20", busy, address); end
    beat(32'd5, 1, a0);           // latency 2 -> miss
    beat(32'd6, 1, a1);
    n_checks++; if ({a0, a1} !== {15'h0020, 15'h0021}) begin n_fail++; $display("FAIL restart_addrs: got %0h %0h expected 20 21", a0, a1); end
    n_checks++; if ({done, dataSum, hitCount, missCount} !== {1'b1, 32'd11, 16'd1, 16'd1}) begin n_fail++; $display("FAIL restart_final: got %b/%0d/%0d/%0d expected 1/11/1/1", done, dataSum, hitCount, missCount); end
    start_run(15'h0040, 16'd0);   // zero length from DONE
    n_checks++; if ({done, dataSum, hitCount, missCount} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL zero_from_done: got %b/%0d/%0d/%0d expected 1/0/0/0", done, dataSum, hitCount, missCount); end
  endtask

  task automatic test_reset_mid_run();
    logic [14:0] a;
    do_reset();
    start_run(15'h0040, 16'd8);
    beat(32'd1, 1, a);
    beat(32'd2, 1, a);
    n_checks++; if ({address, dataSum} !== {15'h0042, 32'd3}) begin n_fail++; $display("FAIL midrst_pre: got %0h/%0d expected 42/3", address, dataSum); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({busy, done, address, dataSum, hitCount, missCount} !== 81'h0) begin n_fail++; $display("FAIL midrst_clear: got %0h expected 0", {busy, done, address, dataSum, hitCount, missCount}); end
    outData = 32'd9; outDataReady = 1'b1; increment = 1'b1;
    repeat (3) @(negedge clk);
    outData = '0; outDataReady = 1'b0; increment = 1'b0;
    n_checks++; if ({busy, done, address, dataSum, hitCount, missCount, protocolErr} !== 82'h0) begin n_fail++; $display("FAIL midrst_beats_ignored: got %0h expected 0", {busy, done, address, dataSum, hitCount, missCount, protocolErr}); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; baseAddr = '0; numAccesses = '0;
    outData = '0; outDataReady = 1'b0; increment = 1'b0;
    test_reset();
    test_all_hit();
    test_miss_latency();
    test_wrap();
    test_protocol_err();
    test_zero_and_restart();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
